// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - fetches ROM instructions and issues them to the control FSM via Start/Done
module instr_fetch_sequencer #(
    parameter int ADDR_W       = 4,
    parameter int PROG_LEN     = 16,
    parameter int ROM_LAT      = 1,
    parameter int DONE_TIMEOUT = 31
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_Run_mode,
    input  logic              i_Execute_n,
    input  logic              i_Restart,
    input  logic [7:0]        i_Rom_data,
    input  logic              i_Done,
    output logic [ADDR_W-1:0] o_Rom_addr,
    output logic [ADDR_W-1:0] o_Pc,
    output logic [7:0]        o_Opcode,
    output logic              o_Start,
    output logic              o_Busy,
    output logic              o_Halted,
    output logic              o_Error
);

    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT + 1) : 1;
    // Two extra codes of headroom: the watchdog may step once more on the
    // WAIT_DONE -> RETIRE transition that happens in the expiry cycle.
    localparam int WD_W  = $clog2(DONE_TIMEOUT + 2);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LAT - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        RETIRE    = 3'd5,
        HALT      = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [7:0]          r_opcode;
    logic                r_start;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;
    logic                w_error_next;
    logic                w_latch;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [WD_W-1:0]     r_wd_cnt;
    logic                w_wd_expired;
    logic                r_sync_1;
    logic                r_sync_2;
    logic                r_sync_3;
    logic                w_step_pulse;

    // Synchronise the raw pushbutton and keep one extra stage for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
            r_sync_3 <= 1'b1;
        end else begin
            r_sync_1 <= i_Execute_n;
            r_sync_2 <= r_sync_1;
            r_sync_3 <= r_sync_2;
        end
    end

    assign w_step_pulse = r_sync_3 & ~r_sync_2;
    assign w_wd_expired = (r_wd_cnt >= WD_LAST);

    // Next-state, next-Pc and fault decisions for the fetch/issue sequence.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_error_next = r_error;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Restart) begin
                    w_pc_next = '0;
                end else if (i_Run_mode || w_step_pulse) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_next_state = LATCH;
                end
            end
            LATCH: begin
                w_latch      = 1'b1;
                w_next_state = ISSUE;
            end
            ISSUE: begin
                w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Done) begin
                    w_next_state = RETIRE;
                end else if (w_wd_expired) begin
                    w_error_next = 1'b1;
                    w_next_state = HALT;
                end
            end
            RETIRE: begin
                if (!i_Done) begin
                    if (r_pc == LAST_PC) begin
                        w_next_state = HALT;
                    end else begin
                        w_pc_next    = r_pc + ADDR_W'(1);
                        w_next_state = IDLE;
                    end
                end else if (w_wd_expired) begin
                    w_error_next = 1'b1;
                    w_next_state = HALT;
                end
            end
            HALT: begin
                if (i_Restart) begin
                    w_pc_next    = '0;
                    w_error_next = 1'b0;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, Pc, fault flag and the ROM-latency / watchdog counters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_error   <= 1'b0;
            r_lat_cnt <= '0;
            r_wd_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_error <= w_error_next;
            if (r_state == FETCH) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end else begin
                r_lat_cnt <= '0;
            end
            if (r_state == WAIT_DONE || r_state == RETIRE) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_opcode <= 8'h00;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (w_latch) begin
                r_opcode <= i_Rom_data;
            end
            r_start  <= (w_next_state == ISSUE);
            r_busy   <= (w_next_state == FETCH) || (w_next_state == LATCH) ||
                        (w_next_state == ISSUE) || (w_next_state == WAIT_DONE) ||
                        (w_next_state == RETIRE);
            r_halted <= (w_next_state == HALT);
        end
    end

    assign o_Rom_addr = r_pc;
    assign o_Pc       = r_pc;
    assign o_Opcode   = r_opcode;
    assign o_Start    = r_start;
    assign o_Busy     = r_busy;
    assign o_Halted   = r_halted;
    assign o_Error    = r_error;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - scoreboard bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

    localparam int ADDR_W       = 4;
    localparam int PROG_LEN     = 4;
    localparam int ROM_LAT      = 1;
    localparam int DONE_TIMEOUT = 31;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              i_Run_mode = 1'b0;
    logic              i_Execute_n = 1'b1;
    logic              i_Restart = 1'b0;
    logic [7:0]        i_Rom_data = 8'h00;
    logic              i_Done;
    logic [ADDR_W-1:0] o_Rom_addr;
    logic [ADDR_W-1:0] o_Pc;
    logic [7:0]        o_Opcode;
    logic              o_Start;
    logic              o_Busy;
    logic              o_Halted;
    logic              o_Error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rom [0:15];
    logic [11:0] exp_q [$];
    logic [11:0] exp_item;
    logic        prev_start = 1'b0;
    int          done_en = 0;
    int          done_delay = 2;
    int          done_len = 1;
    int          n;

    instr_fetch_sequencer #(
        .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .ROM_LAT(ROM_LAT), .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .i_Run_mode(i_Run_mode), .i_Execute_n(i_Execute_n),
        .i_Restart(i_Restart), .i_Rom_data(i_Rom_data), .i_Done(i_Done),
        .o_Rom_addr(o_Rom_addr), .o_Pc(o_Pc), .o_Opcode(o_Opcode), .o_Start(o_Start),
        .o_Busy(o_Busy), .o_Halted(o_Halted), .o_Error(o_Error)
    );

    always #5 Clock = ~Clock;

    // one-cycle-latency ROM
    always @(posedge Clock) i_Rom_data <= rom[o_Rom_addr];

    // Done responder: after a Start, raise Done for done_len cycles
    initial begin
        i_Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (o_Start && done_en != 0 && Reset) begin
                repeat (done_delay - 1) @(negedge Clock);
                i_Done = 1'b1;
                repeat (done_len) @(negedge Clock);
                i_Done = 1'b0;
            end
        end
    end

    // scoreboard: every Start pops the expected {Pc, Opcode}
    always @(negedge Clock) begin
        if (Reset && o_Start) begin
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_width: Start high for 2 cycles at Pc=%0d, required 1", o_Pc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: Start at Pc=%0d Opcode=%02h, required none", o_Pc, o_Opcode);
            end else begin
                exp_item = exp_q.pop_front();
                if ({o_Pc, o_Opcode} !== exp_item || o_Rom_addr !== o_Pc) begin
                    errors++;
                    $display("FAIL issue: Pc=%0d Rom_addr=%0d Opcode=%02h, required Pc=%0d Opcode=%02h",
                             o_Pc, o_Rom_addr, o_Opcode, exp_item[11:8], exp_item[7:0]);
                end
            end
        end
        prev_start = o_Start;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task test_reset;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({o_Pc, o_Rom_addr, o_Opcode, o_Start, o_Busy, o_Halted, o_Error} !== '0) begin
            errors++;
            $display("FAIL reset_state: Pc=%0d Rom_addr=%0d Opcode=%02h Start=%b Busy=%b Halted=%b Error=%b, required all 0",
                     o_Pc, o_Rom_addr, o_Opcode, o_Start, o_Busy, o_Halted, o_Error);
        end
        Reset = 1'b1;
        repeat (5) @(negedge Clock);
        checks++;
        if (o_Busy !== 1'b0 || o_Pc !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: Busy=%b Pc=%0d, required Busy=0 Pc=0", o_Busy, o_Pc);
        end
    endtask

    task test_run_mode;
        for (int i = 0; i < PROG_LEN; i++) exp_q.push_back({4'(i), rom[i]});
        done_en = 1; done_delay = 2; done_len = 1;
        i_Run_mode = 1'b1;
        n = 0;
        while (!o_Start && n < 20) begin @(negedge Clock); n++; end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL run_latency: first Start after %0d cycles, required 3", n);
        end
        n = 0;
        while (!o_Halted && n < 300) begin @(negedge Clock); n++; end
        i_Run_mode = 1'b0;
        checks++;
        if (o_Halted !== 1'b1) begin
            errors++;
            $display("FAIL run_halt: Halted=%b, required 1", o_Halted);
        end
        checks++;
        if (o_Pc !== 4'(PROG_LEN - 1) || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL run_end_pc: Pc=%0d Busy=%b, required Pc=%0d Busy=0", o_Pc, o_Busy, PROG_LEN - 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_count: %0d instructions not issued, required 0", exp_q.size());
        end
    endtask

    task test_halt;
        i_Execute_n = 1'b0;
        repeat (5) @(negedge Clock);
        i_Execute_n = 1'b1;
        repeat (5) @(negedge Clock);
        checks++;
        if (o_Halted !== 1'b1 || o_Pc !== 4'(PROG_LEN - 1)) begin
            errors++;
            $display("FAIL halt_hold: Halted=%b Pc=%0d, required Halted=1 Pc=%0d", o_Halted, o_Pc, PROG_LEN - 1);
        end
        i_Restart = 1'b1;
        @(negedge Clock);
        i_Restart = 1'b0;
        @(negedge Clock);
        checks++;
        if (o_Pc !== 4'd0 || o_Halted !== 1'b0 || o_Busy !== 1'b0 || o_Error !== 1'b0) begin
            errors++;
            $display("FAIL halt_restart: Pc=%0d Halted=%b Busy=%b Error=%b, required 0 0 0 0",
                     o_Pc, o_Halted, o_Busy, o_Error);
        end
    endtask

    task test_single_step;
        repeat (10) @(negedge Clock);
        checks++;
        if (o_Busy !== 1'b0 || o_Pc !== 4'd0) begin
            errors++;
            $display("FAIL step_no_press: Busy=%b Pc=%0d, required Busy=0 Pc=0", o_Busy, o_Pc);
        end
        exp_q.push_back({4'd0, rom[0]});
        done_en = 1; done_delay = 12; done_len = 1;
        i_Execute_n = 1'b0;
        n = 0;
        while (!o_Busy && n < 10) begin @(negedge Clock); n++; end
        i_Execute_n = 1'b1;
        repeat (2) @(negedge Clock);
        i_Execute_n = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if (o_Busy !== 1'b1) begin
            errors++;
            $display("FAIL step_busy: Busy=%b during second press, required 1", o_Busy);
        end
        i_Execute_n = 1'b1;
        n = 0;
        while (o_Busy && n < 60) begin @(negedge Clock); n++; end
        repeat (10) @(negedge Clock);
        checks++;
        if (o_Pc !== 4'd1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL step_one_per_press: Pc=%0d Busy=%b, required Pc=1 Busy=0", o_Pc, o_Busy);
        end
        done_delay = 2;
        exp_q.push_back({4'd1, rom[1]});
        i_Execute_n = 1'b0;
        repeat (3) @(negedge Clock);
        i_Execute_n = 1'b1;
        n = 0;
        while (o_Busy && n < 40) begin @(negedge Clock); n++; end
        repeat (3) @(negedge Clock);
        checks++;
        if (o_Pc !== 4'd2) begin
            errors++;
            $display("FAIL step_second: Pc=%0d, required 2", o_Pc);
        end
    endtask

    task test_watchdog;
        done_en = 0;
        exp_q.push_back({4'd2, rom[2]});
        i_Execute_n = 1'b0;
        n = 0;
        while (!o_Start && n < 20) begin @(negedge Clock); n++; end
        i_Execute_n = 1'b1;
        n = 0;
        while (!o_Error && n < 100) begin @(negedge Clock); n++; end
        checks++;
        if (n != DONE_TIMEOUT + 1) begin
            errors++;
            $display("FAIL wd_timing: Error rose %0d cycles after Start, required %0d", n, DONE_TIMEOUT + 1);
        end
        checks++;
        if (o_Error !== 1'b1 || o_Halted !== 1'b1 || o_Pc !== 4'd2) begin
            errors++;
            $display("FAIL wd_state: Error=%b Halted=%b Pc=%0d, required 1 1 2", o_Error, o_Halted, o_Pc);
        end
        i_Restart = 1'b1;
        @(negedge Clock);
        i_Restart = 1'b0;
        @(negedge Clock);
        checks++;
        if (o_Error !== 1'b0 || o_Halted !== 1'b0 || o_Pc !== 4'd0) begin
            errors++;
            $display("FAIL wd_restart: Error=%b Halted=%b Pc=%0d, required 0 0 0", o_Error, o_Halted, o_Pc);
        end
    endtask

    task test_done_long;
        done_en = 1; done_delay = 2; done_len = 3;
        exp_q.push_back({4'd0, rom[0]});
        i_Execute_n = 1'b0;
        n = 0;
        while (!o_Busy && n < 10) begin @(negedge Clock); n++; end
        i_Execute_n = 1'b1;
        n = 0;
        while (o_Busy && n < 40) begin @(negedge Clock); n++; end
        repeat (5) @(negedge Clock);
        checks++;
        if (o_Pc !== 4'd1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL done_long: Pc=%0d Busy=%b, required Pc=1 Busy=0", o_Pc, o_Busy);
        end
    endtask

    task test_reset_mid;
        done_len = 1;
        exp_q.push_back({4'd1, rom[1]});
        i_Execute_n = 1'b0;
        n = 0;
        while (!o_Busy && n < 10) begin @(negedge Clock); n++; end
        i_Execute_n = 1'b1;
        n = 0;
        while (o_Busy && n < 40) begin @(negedge Clock); n++; end
        repeat (3) @(negedge Clock);
        done_en = 0;
        exp_q.push_back({4'd2, rom[2]});
        i_Execute_n = 1'b0;
        n = 0;
        while (!o_Start && n < 20) begin @(negedge Clock); n++; end
        i_Execute_n = 1'b1;
        repeat (3) @(negedge Clock);
        i_Restart = 1'b1;
        @(negedge Clock);
        i_Restart = 1'b0;
        @(negedge Clock);
        checks++;
        if (o_Busy !== 1'b1 || o_Pc !== 4'd2 || o_Opcode !== rom[2]) begin
            errors++;
            $display("FAIL restart_busy: Busy=%b Pc=%0d Opcode=%02h, required Busy=1 Pc=2 Opcode=%02h",
                     o_Busy, o_Pc, o_Opcode, rom[2]);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({o_Pc, o_Opcode, o_Start, o_Busy, o_Halted, o_Error} !== '0) begin
            errors++;
            $display("FAIL async_reset: Pc=%0d Opcode=%02h Start=%b Busy=%b Halted=%b Error=%b, required all 0",
                     o_Pc, o_Opcode, o_Start, o_Busy, o_Halted, o_Error);
        end
        @(negedge Clock);
        Reset = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL issue_count: %0d instructions never issued, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(255));
        rom[0] = 8'h05;
        rom[1] = 8'h6C;
        rom[2] = 8'hC1;
        rom[3] = 8'h3A;
        test_reset;
        test_run_mode;
        test_halt;
        test_single_step;
        test_watchdog;
        test_done_long;
        test_reset_mid;
        repeat (3) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
